// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer for an SRAM-like request/response bus.
// Optional LL/SC link-bit support is compiled in when MEM_SC_EN is defined.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic              req_ll,
  input  logic [1:0]        mem_sel,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              llbit_clr,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              adel,
  output logic              ades,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              is_sc, is_wr, misaligned, accept, sc_skip, bus_done, store_result;
  logic              wr_p1, unsigned_p1;
  logic [1:0]        sel_p1, size_p1;
  logic [3:0]        wstrb_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1, rdata_p1;

  function automatic logic [1:0] size_of(input logic [1:0] sel);
    case (sel)
      2'd1:    return 2'd0;
      2'd2:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] strobe_of(input logic [1:0] sel, input logic [1:0] off);
    case (sel)
      2'd1:    return 4'b0001 << off;
      2'd2:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] sel, input logic [DATA_W-1:0] w);
    case (sel)
      2'd1:    return {4{w[7:0]}};
      2'd2:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_align(input logic [DATA_W-1:0] raw, input logic [1:0] off,
                                                   input logic [1:0] sel, input logic uns);
    logic [DATA_W-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (sel)
      2'd1:    return uns ? {{(DATA_W-8){1'b0}}, sh[7:0]} : {{(DATA_W-8){sh[7]}}, sh[7:0]};
      2'd2:    return uns ? {{(DATA_W-16){1'b0}}, sh[15:0]} : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      default: return raw;
    endcase
  endfunction

  // sc is always a word store, whatever req_wr says
  assign is_sc = (mem_sel == 2'd0);
  assign is_wr = req_wr | is_sc;

  always_comb begin
    case (mem_sel)
      2'd1:    misaligned = 1'b0;
      2'd2:    misaligned = addr[0];
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  assign accept   = (state == IDLE) && req_valid && !misaligned;
  assign bus_done = ((state == REQ) && data_addr_ok && data_data_ok) ||
                    ((state == WAIT) && data_data_ok);

`ifdef MEM_SC_EN
  logic llbit, ll_p1, sc_p1;

  assign sc_skip      = is_sc && !llbit;
  assign store_result = sc_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ll_p1 <= 1'b0;
      sc_p1 <= 1'b0;
      llbit <= 1'b0;
    end else begin
      if (accept) begin
        ll_p1 <= req_ll && !is_wr;
        sc_p1 <= is_sc;
      end
      if (llbit_clr)
        llbit <= 1'b0;
      else if ((state == DONE) && ll_p1)
        llbit <= 1'b1;
      else if ((state == DONE) && sc_p1)
        llbit <= 1'b0;
    end
  end
`else
  logic unused_sc;

  assign unused_sc    = req_ll | llbit_clr;
  assign sc_skip      = 1'b0;
  assign store_result = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = sc_skip ? DONE : REQ;
      REQ:  if (data_addr_ok) state_nxt = data_data_ok ? DONE : WAIT;
      WAIT: if (data_data_ok) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs are gated by rst_n so they read zero during reset
  always_comb begin
    stall    = rst_n && (accept || (state == REQ) || (state == WAIT));
    done     = (state == DONE);
    data_req = (state == REQ);
    data_wr  = (state == REQ) && wr_p1;
    adel     = rst_n && (state == IDLE) && req_valid && misaligned && !is_wr;
    ades     = rst_n && (state == IDLE) && req_valid && misaligned && is_wr;
  end

  // Request latch at accept, result capture at bus completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_p1       <= 1'b0;
      unsigned_p1 <= 1'b0;
      sel_p1      <= 2'd0;
      size_p1     <= 2'd0;
      wstrb_p1    <= 4'b0000;
      addr_p1     <= '0;
      wdata_p1    <= '0;
      rdata_p1    <= '0;
    end else if (accept) begin
      wr_p1       <= is_wr;
      unsigned_p1 <= load_unsigned;
      sel_p1      <= mem_sel;
      size_p1     <= size_of(mem_sel);
      wstrb_p1    <= is_wr ? strobe_of(mem_sel, addr[1:0]) : 4'b0000;
      addr_p1     <= addr;
      wdata_p1    <= replicate(mem_sel, wdata);
      rdata_p1    <= '0;
    end else if (bus_done) begin
      rdata_p1    <= wr_p1 ? {{(DATA_W-1){1'b0}}, store_result}
                           : load_align(data_rdata, addr_p1[1:0], sel_p1, unsigned_p1);
    end
  end

  assign rdata      = rdata_p1;
  assign data_size  = size_p1;
  assign data_addr  = addr_p1;
  assign data_wstrb = wstrb_p1;
  assign data_wdata = wdata_p1;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer between the MEM pipeline stage and the SRAM-like data bus. Each load/store takes its access size from the mem_sel decode: 0 = sc, 1 = byte, 2 = half word, 3 = word. The block checks alignment, generates byte strobes and replicated write data, and runs the request/response handshake. It stalls the pipeline until the bus completes, then returns aligned and extended load data; it also owns the LL/SC link bit.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; other values unsupported)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage holds a memory instruction
- req_wr  in  1  1 = store (sb/sh/sw/sc), 0 = load
- req_ll  in  1  load is ll (word load that sets the link bit)
- mem_sel  in  2  0 sc, 1 byte, 2 half, 3 word
- load_unsigned  in  1  zero-extend byte/half loads (lbu/lhu)
- addr  in  ADDR_W  effective address
- wdata  in  DATA_W  store data, right-aligned
- llbit_clr  in  1  clear link bit (eret/exception)
- stall  out  1  hold pipeline
- done  out  1  access complete this cycle
- rdata  out  DATA_W  load result or sc success flag
- adel  out  1  load address error
- ades  out  1  store address error
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  ADDR_W  bus address
- data_wstrb  out  4  byte strobes
- data_wdata  out  DATA_W  replicated write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response/write complete
- data_rdata  in  DATA_W  raw read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid=1:
  - Misalignment check: half with addr[0]=1, or word/sc with addr[1:0]!=0.
  - Misaligned: assert adel (load) or ades (store) combinationally; stall=0; no bus access; stay IDLE.
  - Aligned: latch request, go to REQ.
- sc handling:
  - Link bit clear: no bus access; go directly to DONE with rdata=0.
  - Link bit set: word store; rdata=1 at DONE; link bit cleared.
- REQ:
  - data_req=1, all bus outputs driven from latched registers.
  - data_addr_ok=1 → WAIT.
  - data_addr_ok=1 and data_data_ok=1 in the same cycle → DONE.
- WAIT: data_data_ok=1 → DONE; load captures data_rdata.
- DONE: done=1, stall=0, rdata valid; return to IDLE next cycle.
- Strobes:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
  - Loads: data_wstrb=0.
- Write data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load data: shift data_rdata right by addr[1:0]*8, then sign- or zero-extend byte/half per load_unsigned. Word loads pass through unchanged.
- Link bit:
  - Set at DONE of an ll.
  - Cleared by llbit_clr (priority over set) and by a successful sc.
  - Reset value 0.
- stall = req_valid && aligned in IDLE, or state in {REQ, WAIT}.

## Timing
- Reset (async, immediate) values:
  - State IDLE, link bit 0.
  - stall, done, data_req, data_wr, adel, ades all 0.
  - rdata, data_addr, data_wdata, data_wstrb, data_size all 0.
- Reset mid-access: the outstanding bus transaction is abandoned; the bus is reset by the same rst_n.
- Minimum latency with addr_ok and data_ok in the same cycle: accept (cycle 0) → REQ (cycle 1) → DONE (cycle 2). stall is high in cycles 0-1.
- data_req stays high until the addr_ok cycle inclusive. Bus outputs are stable throughout REQ.
- data_data_ok in IDLE or DONE is ignored.
- The pipeline advances at the end of the DONE cycle. req_valid seen in DONE is not re-accepted.

## Configuration
- MEM_SC_EN defined: link bit, req_ll and sc behaviour exactly as above.
- MEM_SC_EN undefined:
  - No link-bit register; req_ll and llbit_clr are ignored.
  - mem_sel=0 is treated as a word store with rdata=0 at DONE.

## Test plan
- lb, addr=0x1003, data_rdata=0x80000000, addr_ok+data_ok in the REQ cycle → data_size=0, rdata=0xFFFFFF80, done at cycle 2.
- lhu, addr=0x2002, data_rdata=0xBEEF1234, data_ok 3 cycles after addr_ok → rdata=0x0000BEEF; stall high until DONE.
- sh, addr=0x10, wdata=0xABCD → data_wstrb=4'b0011, data_wdata=0xABCDABCD, data_wr=1.
- lw, addr=0x5 → adel=1, stall=0, data_req never asserted. sw, addr=0x6 → ades=1.
- ll to 0x40, then sc to 0x40 → sc issues a bus write, rdata=1. A second sc → no data_req, rdata=0.
- ll, then llbit_clr pulse, then sc → rdata=0, no bus write. rst_n low in WAIT → all outputs 0 immediately, state IDLE.
